am_modulator: RTL
=================

# am_modulator

Double-sideband, full-carrier AM modulator stage. It consumes the offset-binary modulating tone `cos_100k` and the signed carrier `cos_1M` from the waveform generator and forms y = carrier × (1 + k·m) in a 4-stage pipeline. The result goes out as a 10-bit offset-binary DAC code. Modulation depth k is runtime-loadable through a handshake and is applied only at a carrier zero crossing, so depth changes are glitch-free.

## Interface
- `DEPTH_INIT`, 8'd128: depth applied at reset, Q0.8 (128 = 50 %).
- `RAMP_DIV`, 16'd64: clocks per soft-start gain step (used only with `AM_SOFT_START_EN`; must be ≥1).
- `TIMEOUT`, 10'd1023: clocks a pending depth waits for a zero crossing before it is forced in.
- `clk`  in  1  system clock, same domain as the waveform generator.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  modulator enable.
- `cos_100k`  in  8  modulating signal, unsigned offset-binary (128 = zero).
- `cos_1M`  in  8  carrier, signed two's complement.
- `depth_in`  in  8  new depth k, Q0.8 unsigned.
- `depth_load`  in  1  single-cycle strobe that captures `depth_in`.
- `depth_busy`  out  1  high while a loaded depth is pending.
- `depth_cur`  out  8  depth currently in use.
- `dac_out`  out  10  modulated output, unsigned offset-binary (512 = zero).
- `out_valid`  out  1  `dac_out` carries modulated data.

## Operation
- s = `cos_100k` − 128, signed 8-bit, range −128..127.
- **Stage 1.** p1 = `depth_cur` × s, signed 17-bit. The carrier is registered alongside as c1.
- **Stage 2.**
  - env2 = 256 + (p1 >>> 7), arithmetic shift, unsigned 9-bit, range 1..509.
  - c2 = c1.
- **Stage 3.** y3 = c2 × env2, signed 17-bit, range −65152..64643.
- **Stage 4.**
  - `dac_out` = (y3 >>> 7) + 512, range 3..1017.
  - The result is clamped to 0..1023 defensively.
  - `dac_out` is forced to 512 when vld[3] = 0.
- **Valid tracking.** A 4-bit shift register vld takes `en` in at vld[0]; `out_valid` = vld[3].
  - The datapath runs every cycle regardless of `en`.
- **Depth handshake.**
  - A `depth_load` pulse captures `depth_in` into `depth_pend`, sets `depth_busy`, and clears the timeout counter.
  - A load while busy overwrites `depth_pend` and restarts the timeout. Only the last value is applied.
  - Apply condition, while busy: the registered sign of the previous `cos_1M` is 1 and the current `cos_1M[7]` is 0 (negative→non-negative crossing).
  - Alternative apply condition: the timeout counter reaches `TIMEOUT`.
  - On apply, `depth_cur` ← `depth_pend` and `depth_busy` ← 0 on the same edge.
  - `depth_load` coinciding with an apply cycle: the new value becomes pending and `busy` stays 1. The old pending value is discarded and is not applied.
- **Depth semantics.**
  - Depth 0 gives a pure carrier.
  - Depth 255 gives ≈99.6 % modulation. The envelope never reaches 0, so the output never overmodulates.

## Timing
- Latency is 4 clocks: inputs sampled at edge N appear on `dac_out` after edge N+4. Throughput is 1 sample per clock.
- A new `depth_cur` affects stage 1 from the edge after apply, so it first appears on `dac_out` 4 clocks later.
- `en` rise: `out_valid` rises 4 clocks later. `en` fall: `out_valid` falls and `dac_out` returns to 512 4 clocks later.
- Reset values:
  - `dac_out` = 512, `out_valid` = 0.
  - `depth_cur` = `DEPTH_INIT`, `depth_busy` = 0.
  - All pipeline registers 0, vld = 0, timeout counter 0, previous-sign register 0.
- Reset asserted mid-operation: a pending depth is discarded.
- The timeout counter is 10-bit and counts only while busy, so it never wraps.

## Configuration
- **`AM_SOFT_START_EN` defined:**
  - A 9-bit gain g is held at 0 while `en` = 0.
  - While `en` = 1, g increments by 1 every `RAMP_DIV` clocks and saturates at 256.
  - Stage 4 computes `dac_out` = ((y3 × g) >>> 15) + 512, with the same clamp and the same 4-clock latency.
  - g resets to 0.
- **`AM_SOFT_START_EN` undefined:** g is constant 256. No ramp counter or extra multiplier is built, and the output is bit-identical to the formula above.

## Test plan
- **Pure carrier.** Depth = 0, `cos_100k` = 37, `cos_1M` = 100 constant, `en` = 1 → `dac_out` = 712 and `out_valid` = 1 from the 4th edge on.
- **Full-depth extremes.** Depth 255 loaded, `cos_1M` = 127:
  - `cos_100k` = 0 → `dac_out` = 512.
  - `cos_100k` = 255 → `dac_out` = 1017.
  - `cos_1M` = −128 with `cos_100k` = 255 → `dac_out` = 3.
- **Zero-crossing apply.** Load 64 while `cos_1M` = −20 → `depth_busy` = 1 and `depth_cur` stays unchanged. Step `cos_1M` to 0 → `depth_cur` = 64 and `busy` = 0 on that edge. A second load one cycle before the crossing → only the second value is applied.
- **Timeout.** `cos_1M` held at 50, load 200 → `depth_cur` = 200 exactly when the counter reaches 1023, `busy` then 0.
- **Reset mid-stream.** Assert `rst_n` low while busy and `out_valid` = 1 → immediately `dac_out` = 512, `out_valid` = 0, `depth_busy` = 0, `depth_cur` = 128.
- **Soft start** (`AM_SOFT_START_EN`, `RAMP_DIV` = 1). Depth 0, `cos_1M` = 100, `en` rises → `dac_out` climbs monotonically from 512 to 712 over ~256 clocks. Same stimulus without the macro → 712 after 4 clocks.

Source files
------------

// File: rtl/am_modulator.sv
// am_modulator: DSB full-carrier AM stage, y = carrier * (1 + k*m), 4-stage pipeline,
// 10-bit offset-binary DAC output. Depth k is loaded through a handshake and applied
// at a negative-to-non-negative carrier crossing, or after TIMEOUT clocks pending.
// Optional build macro: AM_SOFT_START_EN adds an output gain ramp after en rises.
module am_modulator #(
  parameter logic [7:0]  DEPTH_INIT = 8'd128,
  parameter logic [15:0] RAMP_DIV   = 16'd64,
  parameter logic [9:0]  TIMEOUT    = 10'd1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] cos_100k,
  input  logic [7:0] cos_1M,
  input  logic [7:0] depth_in,
  input  logic       depth_load,
  output logic       depth_busy,
  output logic [7:0] depth_cur,
  output logic [9:0] dac_out,
  output logic       out_valid
);

  localparam int unsigned DW = 8;           // depth / sample width
  localparam int unsigned PW = 17;          // stage-1 product and stage-3 product width
  localparam int unsigned EW = 9;           // envelope width
  localparam int unsigned OW = 10;          // DAC code width
  localparam int unsigned TW = 10;          // timeout counter width
  localparam int unsigned VW = 4;           // valid shift register depth
  localparam int unsigned SH = 7;           // Q0.8 depth times signed sample, rescaled
`ifdef AM_SOFT_START_EN
  localparam int unsigned GW = 9;           // soft-start gain width
  localparam int unsigned MW = PW + GW + 1; // y3 * g product width
  localparam int unsigned GSH = 15;
  localparam int unsigned SW = MW;
`else
  localparam int unsigned SW = PW;
`endif

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  // Pipeline registers
  logic signed [DW-1:0] c1, c2;
  logic signed [PW-1:0] p1, y3;
  logic        [EW-1:0] env2;
  logic        [VW-1:0] vld;
  logic                 sign_prev;

  // Depth handshake state
  logic [0:0]    state, state_nxt;
  logic [DW-1:0] depth_pend, pend_nxt, cur_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;

  logic signed [DW-1:0] s_c;
  logic                 zc_c;
  logic                 to_c;
  logic signed [SW-1:0] dac_sum_c;
  logic        [OW-1:0] dac_clamp_c;

  // Offset-binary modulating tone to signed: flip the MSB
  assign s_c = $signed({~cos_100k[7], cos_100k[6:0]});

  assign zc_c = sign_prev & ~cos_1M[7];
  assign to_c = (tcnt == TIMEOUT);

  assign depth_busy = (state == ST_PEND);
  assign out_valid  = vld[VW-1];

  // Datapath pipeline and valid tracking; runs every cycle regardless of en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1        <= '0;
      c2        <= '0;
      p1        <= '0;
      env2      <= '0;
      y3        <= '0;
      vld       <= '0;
      sign_prev <= 1'b0;
      dac_out   <= OW'(512);
    end else begin
      p1        <= PW'($signed({1'b0, depth_cur}) * s_c);
      c1        <= $signed(cos_1M);
      env2      <= EW'($signed(PW'(256)) + (p1 >>> SH));
      c2        <= c1;
      y3        <= PW'($signed(c2) * $signed({1'b0, env2}));
      vld       <= {vld[VW-2:0], en};
      sign_prev <= cos_1M[7];
      dac_out   <= vld[VW-2] ? dac_clamp_c : OW'(512);
    end
  end

`ifdef AM_SOFT_START_EN
  logic [GW-1:0]        gain;
  logic [15:0]          ramp_cnt;
  logic signed [MW-1:0] prod_c;

  // Soft-start gain: held at 0 while disabled, steps every RAMP_DIV clocks up to 256
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain     <= '0;
      ramp_cnt <= '0;
    end else if (!en) begin
      gain     <= '0;
      ramp_cnt <= '0;
    end else if (gain != GW'(256)) begin
      if (ramp_cnt == RAMP_DIV - 16'd1) begin
        ramp_cnt <= '0;
        gain     <= gain + GW'(1);
      end else begin
        ramp_cnt <= ramp_cnt + 16'd1;
      end
    end
  end

  // Stage-4 arithmetic with gain: ((y3 * g) >>> 15) + 512
  always_comb begin
    prod_c    = MW'(y3) * MW'($signed({1'b0, gain}));
    dac_sum_c = (prod_c >>> GSH) + $signed(MW'(512));
  end
`else
  logic ramp_div_unused;
  assign ramp_div_unused = ^RAMP_DIV;

  // Stage-4 arithmetic at unity gain: (y3 >>> 7) + 512
  always_comb begin
    dac_sum_c = (y3 >>> SH) + $signed(PW'(512));
  end
`endif

  // Defensive clamp of the DAC code to 0..1023
  always_comb begin
    dac_clamp_c = dac_sum_c[OW-1:0];
    if (dac_sum_c[SW-1]) begin
      dac_clamp_c = '0;
    end else if (|dac_sum_c[SW-2:OW]) begin
      dac_clamp_c = '1;
    end
  end

  // Depth handshake state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      depth_cur  <= DEPTH_INIT;
      depth_pend <= '0;
      tcnt       <= '0;
    end else begin
      state      <= state_nxt;
      depth_cur  <= cur_nxt;
      depth_pend <= pend_nxt;
      tcnt       <= tcnt_nxt;
    end
  end

  // Depth handshake next state: a load always wins over a simultaneous apply
  always_comb begin
    state_nxt = state;
    cur_nxt   = depth_cur;
    pend_nxt  = depth_pend;
    tcnt_nxt  = tcnt;
    if (depth_load) begin
      pend_nxt  = depth_in;
      tcnt_nxt  = '0;
      state_nxt = ST_PEND;
    end else begin
      case (state)
        ST_PEND: begin
          if (zc_c || to_c) begin
            cur_nxt   = depth_pend;
            tcnt_nxt  = '0;
            state_nxt = ST_IDLE;
          end else begin
            tcnt_nxt = tcnt + TW'(1);
          end
        end
        default: begin
          tcnt_nxt = '0;
        end
      endcase
    end
  end

endmodule
